// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and helpers for the mux scan sequencer.
package mux_scan_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // A requested length of 0, or one longer than the word, means a full-word scan.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n);
    return ((len == 0) || (len > n)) ? n : len;
  endfunction

  // Select must cover every mux input; the length field must be able to encode N.
  function automatic bit params_ok(input int unsigned n, input int unsigned m,
                                   input int unsigned lw);
    return (n >= 1) && (m >= 1) && (lw >= 1) &&
           ((64'(1) << m) >= 64'(n)) && ((64'(1) << lw) > 64'(n));
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_counter.sv
// Select up-counter with load/increment/clear and last-index compare against len_q.
module mux_scan_counter
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned M  = 4,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic          clear,
  input  logic [LW-1:0] len_q,
  output logic [M-1:0]  sel,
  output logic          last_c
);

  localparam int unsigned CW = ((M > LW) ? M : LW) + 1;

  logic [M-1:0] sel_q;
  logic [M-1:0] sel_d;
  logic [M:0]   sel_inc;

  // Next select: a new word or a finished word restarts at 0, otherwise step on accept.
  always_comb begin
    sel_inc = {1'b0, sel_q} + (M + 1)'(1);
    sel_d   = sel_q;
    if (load || clear) begin
      sel_d = '0;
    end else if (inc) begin
      sel_d = sel_inc[M-1:0];
    end
  end

  // Widened compare so the final index is detected without relying on wrap.
  assign last_c = (CW'(sel_inc) == CW'(len_q));

  // Select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Loads an N-bit word over valid/ready and steps sel across it, one index per accepted beat.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned N  = 9,
  parameter int unsigned M  = 4,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_data,
  input  logic [LW-1:0] in_len,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  word_q,
  output logic [M-1:0]  sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  if (!params_ok(N, M, LW)) begin : g_param_check
    $fatal(1, "mux_scan_sequencer: need N>=1, 2**M>=N and 2**LW>N");
  end

  state_e        state_q;
  state_e        state_d;
  logic [N-1:0]  word_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic          last_c;
  logic          beat;
  logic          load;

  // Handshake decode; out_ready -> in_ready is the only combinational input path.
  assign out_valid = (state_q == SCAN);
  assign busy      = out_valid;
  assign out_last  = out_valid & last_c;
  assign beat      = out_valid & out_ready;
  assign in_ready  = (state_q == IDLE) | (beat & out_last);
  assign load      = in_valid & in_ready;

  // Next state, held word and clamped length.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    if (load) begin
      state_d = SCAN;
      word_d  = in_data;
      len_d   = LW'(clamp_len(32'(in_len), N));
    end else if (beat && last_c) begin
      state_d = IDLE;
    end
  end

  // State, word and length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= LW'(N);
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
    end
  end

  mux_scan_counter #(
    .M  (M),
    .LW (LW)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .inc    (beat & ~last_c),
    .clear  (beat & last_c),
    .len_q  (len_q),
    .sel    (sel),
    .last_c (last_c)
  );

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed scoreboard bench for mux_scan_sequencer (N=9 instance and N=1 instance).
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [8:0] in_data9, word9;
  logic [3:0] in_len9, sel9;
  logic       in_valid9, in_ready9, out_valid9, out_ready9, out_last9, busy9;

  logic [0:0] in_data1, word1, in_len1, sel1;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;

  mux_scan_sequencer #(.N(9), .M(4), .LW(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data9), .in_len(in_len9), .in_valid(in_valid9),
    .in_ready(in_ready9), .word_q(word9), .sel(sel9), .out_valid(out_valid9),
    .out_ready(out_ready9), .out_last(out_last9), .busy(busy9));

  mux_scan_sequencer #(.N(1), .M(1), .LW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_len(in_len1), .in_valid(in_valid1),
    .in_ready(in_ready1), .word_q(word1), .sel(sel1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_last(out_last1), .busy(busy1));

  typedef struct packed {
    logic [8:0] word;
    logic [3:0] sel;
    logic       last;
  } beat_t;

  beat_t q9[$];
  logic  q1[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push9(input logic [8:0] d, input logic [3:0] l);
    int len;
    len = ((l == 4'd0) || (l > 4'd9)) ? 9 : int'(l);
    for (int i = 0; i < len; i++) begin
      q9.push_back('{word: d, sel: 4'(i), last: (i == len - 1)});
    end
  endtask

  // One cycle on the N=9 instance: drive, check against model, update model, advance.
  task automatic step9(input logic iv, input logic [8:0] d, input logic [3:0] l,
                       input logic ordy, output logic loaded);
    beat_t f;
    logic  exp_v, exp_rdy;
    logic [8:0] fw;
    in_valid9 = iv; in_data9 = d; in_len9 = l; out_ready9 = ordy;
    #1;
    exp_v = (q9.size() != 0);
    f     = exp_v ? q9[0] : '0;
    fw    = f.word;
    chk("out_valid9", out_valid9, exp_v);
    chk("busy9", busy9, exp_v);
    chk("out_last9", out_last9, exp_v & f.last);
    if (exp_v) begin
      chk("sel9", sel9, f.sel);
      chk("word9", word9, f.word);
      chk("bit9", word9[sel9], fw[f.sel]);
    end
    exp_rdy = !exp_v || (ordy && f.last);
    chk("in_ready9", in_ready9, exp_rdy);
    if (exp_v && ordy) begin
      void'(q9.pop_front());
      beats_acc++;
    end
    loaded = iv && exp_rdy;
    if (loaded) push9(d, l);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send9(input logic [8:0] d, input logic [3:0] l);
    logic ld;
    int   budget;
    ld = 1'b0;
    budget = 40;
    while (!ld && budget > 0) begin
      step9(1'b1, d, l, 1'b1, ld);
      budget--;
    end
    if (!ld) chk("send9_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain9(input int budget);
    logic ld;
    while (q9.size() != 0 && budget > 0) begin
      step9(1'b0, 9'($urandom), 4'($urandom), 1'b1, ld);
      budget--;
    end
    if (q9.size() != 0) chk("drain9_timeout", 32'd0, 32'd1);
  endtask

  // One cycle on the N=1 instance.
  task automatic step1(input logic iv, input logic d, input logic ordy);
    logic exp_v, exp_rdy, f;
    in_valid1 = iv; in_data1 = d; in_len1 = 1'($urandom); out_ready1 = ordy;
    #1;
    exp_v = (q1.size() != 0);
    f     = exp_v ? q1[0] : 1'b0;
    chk("out_valid1", out_valid1, exp_v);
    chk("out_last1", out_last1, exp_v);
    chk("sel1", sel1, 0);
    if (exp_v) chk("word1", word1, f);
    exp_rdy = !exp_v || ordy;
    chk("in_ready1", in_ready1, exp_rdy);
    if (exp_v && ordy) void'(q1.pop_front());
    if (iv && exp_rdy) q1.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic ld;
    rst_n = 1'b1;
    in_valid9 = 0; in_data9 = '0; in_len9 = '0; out_ready9 = 0;
    in_valid1 = 0; in_data1 = '0; in_len1 = '0; out_ready1 = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid9", out_valid9, 0);
    chk("rst_sel9", sel9, 0);
    chk("rst_word9", word9, 0);
    chk("rst_out_last9", out_last9, 0);
    chk("rst_busy9", busy9, 0);
    chk("rst_out_valid1", out_valid1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step9(1'b0, '0, '0, 1'b1, ld);

    // Single full-length word (len 0 means 9).
    send9(9'h1A5, 4'd0);
    drain9(20);

    // Back-to-back full words with in_valid held high.
    send9(9'h0FF, 4'd9);
    send9(9'h100, 4'd9);
    drain9(30);

    // Short, single-beat and clamped lengths, back to back.
    send9(9'h0A5, 4'd3);
    send9(9'h1FF, 4'd1);
    send9(9'h155, 4'd15);
    drain9(30);

    // Backpressure: out_ready 1,0,0,1,0,0,... across a length-5 word.
    send9(9'h0B3, 4'd5);
    beats_acc = 0;
    for (int c = 0; c < 40 && q9.size() != 0; c++) begin
      step9(1'b0, 9'($urandom), 4'($urandom), (c % 3) == 0, ld);
    end
    chk("bp_beats", beats_acc, 5);
    step9(1'b0, '0, '0, 1'b1, ld);

    // Asynchronous reset while sel=4.
    send9(9'h1C3, 4'd0);
    for (int i = 0; i < 4; i++) step9(1'b0, '0, '0, 1'b1, ld);
    chk("pre_rst_sel9", sel9, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid9", out_valid9, 0);
    chk("mid_rst_sel9", sel9, 0);
    chk("mid_rst_word9", word9, 0);
    chk("mid_rst_out_last9", out_last9, 0);
    q9.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step9(1'b0, '0, '0, 1'b1, ld);
    send9(9'h02D, 4'd4);
    drain9(20);
    step9(1'b0, '0, '0, 1'b1, ld);

    // N=1: three words streamed at full rate, then a stalled word.
    step1(1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b1, 1'b1);
    step1(1'b0, 1'b0, 1'b1);
    chk("n1_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
